// File: rtl/mem_stage_ctrl.sv
// mem_stage_ctrl
//   Memory-stage controller between the EX/MEM and MEM/WB pipeline registers.
//   It owns a word-addressed data memory and services one LDR/STR at a time
//   with a fixed latency of WAIT_CYCLES BUSY cycles. While an access is in
//   flight, ready is held low so that PC, IF/ID, ID/EX and EX/MEM freeze.
//
//   Optional feature: define MEM_RANGE_CHECK_EN to flag out-of-range or
//   misaligned accesses. A faulting access suppresses its store, returns 0
//   and raises err_o for its DONE cycle. Without the macro the word index
//   wraps modulo DEPTH and err_o is tied to 0.
//
// Ports
//   clk, rst     clock; asynchronous active-high reset (also clears memory)
//   mem_r_en_i   load request from EX/MEM
//   mem_w_en_i   store request from EX/MEM (wins over a load)
//   wb_en_i      write-back enable from EX/MEM
//   addr_i       byte address (ALU result)
//   wdata_i      store data
//   data_o       registered load data to MEM/WB
//   ready_o      1 = stage may advance, 0 = freeze upstream
//   wb_en_o      wb_en_i gated by ready_o
//   err_o        access-fault flag, valid in the DONE cycle
module mem_stage_ctrl #(
    parameter int BASE_ADDR   = 1024,
    parameter int DEPTH       = 64,
    parameter int WAIT_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_r_en_i,
    input  logic        mem_w_en_i,
    input  logic        wb_en_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] data_o,
    output logic        ready_o,
    output logic        wb_en_o,
    output logic        err_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt;
    logic          req;
    logic          commit;
    logic          fault;
    logic [31:0]   offs;
    logic [AW-1:0] idx;
    logic [31:0]   mem [DEPTH];

    assign req  = mem_r_en_i | mem_w_en_i;
    assign offs = addr_i - 32'(BASE_ADDR);
    assign idx  = offs[AW+1:2];

    // Bits of the offset that do not take part in word selection.
    logic unused_offs;
    assign unused_offs = ^{offs[31:AW+2], offs[1:0]};

`ifdef MEM_RANGE_CHECK_EN
    assign fault = (addr_i < 32'(BASE_ADDR))
                 | (addr_i >= 32'(BASE_ADDR + 4 * DEPTH))
                 | (addr_i[1:0] != 2'b00);
`else
    assign fault = 1'b0;
`endif

    // The access completes on the last BUSY edge; a request that drops in
    // BUSY aborts without touching memory or data_o.
    assign commit = (state == BUSY) & req & (cnt == CNT_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            if (state == BUSY) cnt <= cnt + 1'b1;
            else               cnt <= '0;
        end
    end

    always_comb begin
        state_nxt = state;
        ready_o   = 1'b0;
        case (state)
            IDLE: begin
                ready_o = ~req;
                if (req) state_nxt = BUSY;
            end
            BUSY: begin
                if (!req)        state_nxt = IDLE;
                else if (commit) state_nxt = DONE;
            end
            DONE: begin
                ready_o   = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign wb_en_o = wb_en_i & ready_o;

    // data_o always returns the pre-write word, also for stores.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_o <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (commit) begin
            data_o <= fault ? 32'd0 : mem[idx];
            if (mem_w_en_i && !fault) mem[idx] <= wdata_i;
        end
    end

`ifdef MEM_RANGE_CHECK_EN
    // Registered on the commit edge, so it is high only during DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) err_o <= 1'b0;
        else     err_o <= commit & fault;
    end
`else
    assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_mem_stage_ctrl.sv
module tb_mem_stage_ctrl;

    localparam int WAITC = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_r_en_i, mem_w_en_i, wb_en_i;
    logic [31:0] addr_i, wdata_i;
    logic [31:0] data_o;
    logic        ready_o, wb_en_o, err_o;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];
    logic [31:0] held;
    logic [31:0] w0_val;

    typedef struct {
        logic        r;
        logic        w;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_data;
        logic        exp_err;
    } vec_t;
    vec_t vecs[$];

    mem_stage_ctrl #(.BASE_ADDR(1024), .DEPTH(64), .WAIT_CYCLES(WAITC)) dut (
        .clk(clk), .rst(rst),
        .mem_r_en_i(mem_r_en_i), .mem_w_en_i(mem_w_en_i), .wb_en_i(wb_en_i),
        .addr_i(addr_i), .wdata_i(wdata_i),
        .data_o(data_o), .ready_o(ready_o), .wb_en_o(wb_en_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        mem_r_en_i = 1'b0;
        mem_w_en_i = 1'b0;
        addr_i     = 32'd0;
        wdata_i    = 32'd0;
    endtask

    // Called #1 after a posedge. Drives one access, counts stall cycles and
    // checks the DONE-cycle outputs against the scoreboard entry.
    task automatic run_access(input string name, input logic r, input logic w,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [31:0] exp_data, input logic exp_err);
        int stalls;
        bit bad_stall;
        logic [31:0] e;
        stalls = 0;
        bad_stall = 0;
        mem_r_en_i = r;
        mem_w_en_i = w;
        addr_i     = addr;
        wdata_i    = wdata;
        exp_q.push_back(exp_data);
        forever begin
            @(negedge clk);
            if (ready_o === 1'b1) break;
            if (wb_en_o !== 1'b0 || err_o !== 1'b0) bad_stall = 1;
            stalls++;
            if (stalls > 20) break;
        end
        e = exp_q.pop_front();
        chk({name, ".stall"}, 32'(stalls), 32'(WAITC + 1));
        chk({name, ".stall_wb_err"}, 32'(bad_stall), 32'd0);
        if (stalls <= 20) begin
            chk({name, ".data"}, data_o, e);
            chk({name, ".wb_en"}, 32'(wb_en_o), 32'd1);
            chk({name, ".err"}, 32'(err_o), 32'(exp_err));
            held = e;
        end
        @(posedge clk);
        #1;
        idle_inputs();
    endtask

    initial begin
`ifdef MEM_RANGE_CHECK_EN
        vecs.push_back('{1'b1, 1'b0, 32'd1020, 32'd0,          32'd0,          1'b1});
        vecs.push_back('{1'b0, 1'b1, 32'd1280, 32'h12345678,   32'd0,          1'b1});
        vecs.push_back('{1'b1, 1'b0, 32'd1026, 32'd0,          32'd0,          1'b1});
        vecs.push_back('{1'b1, 1'b0, 32'd1024, 32'd0,          32'd0,          1'b0});
        w0_val = 32'd0;
`else
        vecs.push_back('{1'b0, 1'b1, 32'd1280, 32'h12345678,   32'd0,          1'b0});
        vecs.push_back('{1'b1, 1'b0, 32'd1024, 32'd0,          32'h12345678,   1'b0});
        vecs.push_back('{1'b1, 1'b0, 32'd1284, 32'd0,          32'd0,          1'b0});
        w0_val = 32'h12345678;
`endif
        vecs.push_back('{1'b0, 1'b1, 32'd1032, 32'hDEADBEEF,   32'd0,          1'b0});
        vecs.push_back('{1'b1, 1'b0, 32'd1032, 32'd0,          32'hDEADBEEF,   1'b0});
        vecs.push_back('{1'b0, 1'b1, 32'd1036, 32'd7,          32'd0,          1'b0});
        vecs.push_back('{1'b1, 1'b1, 32'd1036, 32'd5,          32'd7,          1'b0});
        vecs.push_back('{1'b1, 1'b0, 32'd1036, 32'd0,          32'd5,          1'b0});

        idle_inputs();
        wb_en_i = 1'b1;
        rst = 1'b1;
        #12;
        chk("reset.data", data_o, 32'd0);
        chk("reset.ready", 32'(ready_o), 32'd1);
        chk("reset.wb_en", 32'(wb_en_o), 32'd1);
        chk("reset.err", 32'(err_o), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < vecs.size(); i++)
            run_access($sformatf("vec%0d", i), vecs[i].r, vecs[i].w, vecs[i].addr,
                       vecs[i].wdata, vecs[i].exp_data, vecs[i].exp_err);

        // Non-memory instruction stream: no stall, data_o held.
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk($sformatf("nonmem%0d.ready_wb", i), {30'd0, ready_o, wb_en_o}, 32'd3);
            chk($sformatf("nonmem%0d.data", i), data_o, held);
        end
        @(posedge clk);
        #1;

        // Abort: store dropped in BUSY cycle 2 must not commit.
        mem_w_en_i = 1'b1;
        addr_i     = 32'd1036;
        wdata_i    = 32'd99;
        @(posedge clk);
        @(posedge clk);
        #1;
        idle_inputs();
        @(negedge clk);
        chk("abort.ready_busy", 32'(ready_o), 32'd0);
        @(negedge clk);
        chk("abort.ready_idle", 32'(ready_o), 32'd1);
        chk("abort.data", data_o, held);
        @(posedge clk);
        #1;
        run_access("abort.readback", 1'b1, 1'b0, 32'd1036, 32'd0, 32'd5, 1'b0);

        // Reset in the middle of an access.
        run_access("pre_rst.st", 1'b0, 1'b1, 32'd1024, 32'hAAAA5555, w0_val, 1'b0);
        run_access("pre_rst.ld", 1'b1, 1'b0, 32'd1024, 32'd0, 32'hAAAA5555, 1'b0);
        mem_r_en_i = 1'b1;
        addr_i     = 32'd1036;
        @(posedge clk);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst.data", data_o, 32'd0);
        chk("mid_rst.err", 32'(err_o), 32'd0);
        idle_inputs();
        #1;
        chk("mid_rst.ready", 32'(ready_o), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        run_access("post_rst.1024", 1'b1, 1'b0, 32'd1024, 32'd0, 32'd0, 1'b0);
        run_access("post_rst.1032", 1'b1, 1'b0, 32'd1032, 32'd0, 32'd0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_stage_ctrl.md
# mem_stage_ctrl

Memory-stage controller for the ARM pipeline: sits between the EX/MEM pipeline register and the MEM/WB register. It owns the word-addressed data memory and executes LDR/STR accesses with a fixed multi-cycle latency. It produces load data for MEM/WB and a `ready_o` freeze signal that stalls all upstream pipeline registers until the access completes.

## Interface
- `BASE_ADDR`, 1024: byte address of data-memory word 0.
- `DEPTH`, 64: number of 32-bit words; power of two.
- `WAIT_CYCLES`, 4: BUSY cycles per access; must be ≥1.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  asynchronous, active-high reset.
- `mem_r_en_i`  in  1  load request from EX/MEM.
- `mem_w_en_i`  in  1  store request from EX/MEM.
- `wb_en_i`  in  1  write-back enable from EX/MEM.
- `addr_i`  in  32  byte address (ALU result).
- `wdata_i`  in  32  store data (Val_Rm).
- `data_o`  out  32  load data to MEM/WB; registered.
- `ready_o`  out  1  1 = stage may advance; 0 = freeze PC, IF/ID, ID/EX, EX/MEM.
- `wb_en_o`  out  1  `wb_en_i & ready_o`, to MEM/WB.
- `err_o`  out  1  access-fault flag. Only active with the macro; otherwise tied to 0.

## Operation
- `req = mem_r_en_i | mem_w_en_i`.
- Word index: `idx = (addr_i - BASE_ADDR) >> 2`, truncated to log2(DEPTH) bits.
- FSM states:
  - IDLE: if `req`, go to BUSY and set `cnt <= 0`; otherwise stay in IDLE.
  - BUSY: `cnt <= cnt + 1`. When `cnt == WAIT_CYCLES-1`, go to DONE. On that same edge:
    - a store commits `mem[idx] <= wdata_i`;
    - `data_o` latches `mem[idx]`, the value before any same-edge write.
  - DONE: unconditionally return to IDLE. The pipeline advances on this edge.
- `ready_o` is combinational: `ready_o = (state==DONE) | (state==IDLE & ~req)`.
- Non-memory instructions pass with `ready_o=1` and no stall. `data_o` holds its last value.
- If both enables are set, the store takes priority. `data_o` still returns the pre-write word.
- Inputs must stay stable while `ready_o=0`; upstream freeze guarantees this.
- Abort: if `req` drops while in BUSY, return to IDLE on the next edge with no commit and `data_o` unchanged.
- Reset clears all memory words to 0.

## Timing
- Reset values: state=IDLE, cnt=0, `data_o=0`, `err_o=0`, all memory words 0. With no request, `ready_o=1` and `wb_en_o=wb_en_i`.
- A request first visible in cycle T:
  - T: IDLE, `ready_o=0`.
  - T+1 … T+WAIT_CYCLES: BUSY, `ready_o=0`.
  - T+WAIT_CYCLES+1: DONE, `ready_o=1`, `data_o` valid.
  - Total stall: WAIT_CYCLES+1 cycles; 5 at the defaults.
- MEM/WB captures `data_o` and `wb_en_o=1` on the edge ending the DONE cycle. During the stall `wb_en_o=0`, so no premature write-back or forwarding of stale load data.
- Back-to-back memory instructions: the second one enters IDLE in the cycle after DONE, then stalls again. There is no pipelining of accesses.
- Reset asserted mid-access: immediate return to IDLE with no commit. The memory array is cleared.

## Configuration
- `MEM_RANGE_CHECK_EN`, when defined, classifies an access as a fault if:
  - `addr_i < BASE_ADDR`, or
  - `addr_i >= BASE_ADDR + 4*DEPTH`, or
  - `addr_i[1:0] != 0`.
- A faulting access keeps the same FSM timing, with these effects:
  - its store is suppressed;
  - `data_o` latches 0;
  - `err_o` is high for exactly the DONE cycle, and 0 otherwise.
- When the macro is undefined, the index wraps modulo DEPTH, the low address bits are ignored, and `err_o` is constant 0.

## Test plan
- **Reset:** assert `rst` mid-BUSY.
  - Outputs go to 0 immediately; `ready_o=1` with no request.
  - A prior store to 1024 reads back 0.
- **Store then load:** STR 0xDEADBEEF to 1032, then LDR 1032.
  - Each access holds `ready_o` low exactly 5 cycles.
  - `data_o=0xDEADBEEF` in the load's DONE cycle, with `wb_en_o=1` only in that cycle.
- **Non-memory stream:** `wb_en_i=1`, no request, for 10 cycles.
  - `ready_o=1` and `wb_en_o=1` throughout; `data_o` unchanged.
- **Abort and dual enable:**
  - Drop `mem_w_en_i` at BUSY cycle 2 → no write, and the word stays at its old value.
  - Both enables with `wdata_i=5` on a word holding 7 → `data_o=7`, and the word becomes 5.
- **Address range, macro defined:** LDR 1020, STR 1280, LDR 1026.
  - Each gives `err_o=1` in DONE and `data_o=0`; the memory is unchanged.
- **Address range, macro undefined:** STR to 1280 aliases to word 0 (address 1024) at DEPTH=64, and `err_o` stays 0.
